fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NRD, default 2, number of operand read ports.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages after decode (E, M, W).
REQ-003 SHALL have parameter TW, default 2, width of Tnew/Tuse fields.
REQ-004 SHALL have parameter DW, default 32, data width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 iss_valid  in  1  decode issues an instruction into stage 0 this cycle.
REQ-008 iss_dst  in  5  destination register of the issuing instruction; 0 = no write.
REQ-009 iss_tnew  in  TW  cycles until the issuing result is produced.
REQ-010 flush  in  1  clear all tracked entries.
REQ-011 rd_addr  in  NRD*5  per-port source register.
REQ-012 rd_tuse  in  NRD*TW  per-port cycles until the operand is consumed.
REQ-013 rf_data  in  NRD*DW  per-port register-file read value.
REQ-014 stg_data  in  DEPTH*DW  result value currently held in each tracked stage.
REQ-015 fwd_data  out  NRD*DW  per-port forwarded operand.
REQ-016 fwd_sel  out  NRD*clog2(DEPTH+1)  per-port source: 0 = rf_data, k = stage k-1.
REQ-017 stall  out  1  freeze decode and insert a bubble into stage 0.

Function
REQ-018 SHALL hold DEPTH entries {valid, dst, tnew}; entry 0 is the youngest.
REQ-019 SHALL, each clock without flush, shift entry k into k+1 and drop entry DEPTH-1.
REQ-020 SHALL decrement tnew by 1 on every shift, saturating at 0.
REQ-021 SHALL load entry 0 from iss_* when iss_valid=1 and stall=0; otherwise load a bubble (valid=0).
REQ-022 SHALL treat entries with dst=0 as non-matching.
REQ-023 SHALL, per port, match the youngest valid entry with dst=rd_addr; older matches ignored.
REQ-024 SHALL assert stall combinationally when any port's matched entry has tnew > rd_tuse.
REQ-025 SHALL, for a match with tnew=0, set fwd_sel=k+1 and fwd_data=stg_data[k]; with no match, fwd_sel=0 and fwd_data=rf_data.
REQ-026 SHALL drive fwd_data from rf_data and fwd_sel=0 when the match is stalling (value don't-care to pipeline, fixed for verification).
REQ-027 SHALL give flush priority over shift: all entries invalid next cycle, issue discarded.
REQ-028 SHALL never assert stall when rd_addr=0.

Reset
REQ-029 SHALL clear all entries to valid=0, dst=0, tnew=0 while reset=0, asynchronously.
REQ-030 SHALL output stall=0, fwd_sel=0, fwd_data=rf_data during and immediately after reset.
REQ-031 SHALL discard an instruction issued in the cycle reset asserts.

Configuration
REQ-032 With FWD_STATS_EN defined, SHALL add output stall_cnt (32 bits), incremented each cycle stall=1, saturating at all-ones, cleared by reset, not cleared by flush.
REQ-033 Without FWD_STATS_EN, SHALL have no stall_cnt port and no counter logic.

Structure
REQ-034 SHALL place fwd_sel encoding constants (SEL_RF=0) and the entry record typedef in the shared pipeline constants package alongside existing forwarding codes.
REQ-035 SHALL implement per-port matching/select as one sub-module, fwd_port_match, instantiated NRD times.

Verification
REQ-036 Issue dst=5 tnew=0; next cycle port0 rd_addr=5 tuse=0 -> stall=0, fwd_sel=1, fwd_data=stg_data[0].
REQ-037 Issue dst=5 tnew=2 (load); next cycle rd_addr=5 tuse=0 -> stall=1 one cycle, then fwd_sel=2 from stage M.
REQ-038 Issue dst=7 twice back-to-back, then read 7 -> fwd_sel selects the younger (stage 0) entry.
REQ-039 rd_addr=0 with entry dst=0 tnew=2 -> stall=0, fwd_sel=0.
REQ-040 Pending dst=3 tnew=2, assert flush -> next cycle rd_addr=3 gives stall=0, fwd_sel=0.
REQ-041 Reset asserted mid-stall (entry tnew=2) -> stall drops immediately; with FWD_STATS_EN stall_cnt reads 0.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline forwarding constants: operand source codes and the in-flight entry record.
package fwd_scoreboard_pkg;

  localparam int DST_W  = 5;
  localparam int TNEW_W = 4;

  // fwd_sel codes: SEL_RF picks the register file; k picks in-flight stage k-1
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [DST_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
  } fwd_entry_t;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == {TNEW_W{1'b0}}) ? {TNEW_W{1'b0}} : t - TNEW_W'(1);
  endfunction

  function automatic fwd_entry_t age_entry(input fwd_entry_t e);
    fwd_entry_t r;
    r      = e;
    r.tnew = tnew_dec(e.tnew);
    return r;
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port hazard match: finds the youngest producer of rd_addr, decides stall and bypass source.
module fwd_port_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int DW    = 32,
  parameter int SW    = 2
) (
  input  fwd_entry_t [DEPTH-1:0] entries,
  input  logic [DST_W-1:0]       rd_addr,
  input  logic [TW-1:0]          rd_tuse,
  input  logic [DW-1:0]          rf_data,
  input  logic [DEPTH*DW-1:0]    stg_data,
  output logic [DW-1:0]          fwd_data,
  output logic [SW-1:0]          fwd_sel,
  output logic                   stall
);

  logic              hit_s;
  logic [SW-1:0]     hit_idx_s;
  logic [TNEW_W-1:0] hit_tnew_s;

  // Scan oldest to youngest so the youngest matching entry wins; dst=0 never matches
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {SW{1'b0}};
    hit_tnew_s = {TNEW_W{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && (entries[k].dst != {DST_W{1'b0}}) && (entries[k].dst == rd_addr)) begin
        hit_s      = 1'b1;
        hit_idx_s  = SW'(k);
        hit_tnew_s = entries[k].tnew;
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Bypass only results already produced; pending or stalling matches read the register file
  always_comb begin
    stall    = hit_s && (hit_tnew_s > TNEW_W'(rd_tuse));
    fwd_sel  = SW'(SEL_RF);
    fwd_data = rf_data;
    if (hit_s && (hit_tnew_s == {TNEW_W{1'b0}})) begin
      fwd_sel  = hit_idx_s + SW'(1);
      fwd_data = stg_data[int'(hit_idx_s)*DW +: DW];
    end else begin
      fwd_sel  = SW'(SEL_RF);
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard tracking in-flight producers and resolving operand bypass/stall.
// Optional FWD_STATS_EN adds a saturating stall_cnt output.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int DW    = 32,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic [4:0]          iss_dst,
  input  logic [TW-1:0]       iss_tnew,
  input  logic                flush,
  input  logic [NRD*5-1:0]    rd_addr,
  input  logic [NRD*TW-1:0]   rd_tuse,
  input  logic [NRD*DW-1:0]   rf_data,
  input  logic [DEPTH*DW-1:0] stg_data,
  output logic [NRD*DW-1:0]   fwd_data,
  output logic [NRD*SW-1:0]   fwd_sel,
`ifdef FWD_STATS_EN
  output logic [31:0]         stall_cnt,
`endif
  output logic                stall
);

  fwd_entry_t [DEPTH-1:0] entries_r;
  fwd_entry_t             issue_entry_s;
  logic [NRD-1:0]         port_stall_s;

  assign stall = |port_stall_s;

  // Stage-0 candidate; tnew is aged once on entry so it counts from decode
  always_comb begin
    issue_entry_s = '0;
    if (iss_valid && !stall) begin
      issue_entry_s.valid = 1'b1;
      issue_entry_s.dst   = iss_dst;
      issue_entry_s.tnew  = tnew_dec(TNEW_W'(iss_tnew));
    end else begin
      issue_entry_s = '0;
    end
  end

  // Entry pipeline: flush clears everything, otherwise age and shift toward the oldest slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_r <= '0;
    end else if (flush) begin
      entries_r <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries_r[k] <= age_entry(entries_r[k-1]);
      end
      entries_r[0] <= issue_entry_s;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .TW    (TW),
      .DW    (DW),
      .SW    (SW)
    ) u_match (
      .entries  (entries_r),
      .rd_addr  (rd_addr[p*5 +: 5]),
      .rd_tuse  (rd_tuse[p*TW +: TW]),
      .rf_data  (rf_data[p*DW +: DW]),
      .stg_data (stg_data),
      .fwd_data (fwd_data[p*DW +: DW]),
      .fwd_sel  (fwd_sel[p*SW +: SW]),
      .stall    (port_stall_s[p])
    );
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating stall-cycle counter; survives flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (default parameters).
module tb_fwd_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic         iss_valid;
  logic [4:0]   iss_dst;
  logic [1:0]   iss_tnew;
  logic         flush;
  logic [9:0]   rd_addr;
  logic [3:0]   rd_tuse;
  logic [63:0]  rf_data;
  logic [95:0]  stg_data;
  logic [63:0]  fwd_data;
  logic [3:0]   fwd_sel;
  logic         stall;
`ifdef FWD_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] RF0  = 32'h1111_0000;
  localparam logic [31:0] RF1  = 32'h2222_0000;
  localparam logic [31:0] STG0 = 32'hA0A0_0000;
  localparam logic [31:0] STG1 = 32'hB1B1_1111;
  localparam logic [31:0] STG2 = 32'hC2C2_2222;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_dst   (iss_dst),
    .iss_tnew  (iss_tnew),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_tuse   (rd_tuse),
    .rf_data   (rf_data),
    .stg_data  (stg_data),
    .fwd_data  (fwd_data),
    .fwd_sel   (fwd_sel),
`ifdef FWD_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .stall     (stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    iss_valid = 1'b0;
    rd_addr   = 10'd0;
    rd_tuse   = 4'd0;
    tick();
    flush     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [1:0] tnew);
    iss_valid = 1'b1;
    iss_dst   = dst;
    iss_tnew  = tnew;
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    iss_valid = 1'b1;
    iss_dst   = 5'd9;
    iss_tnew  = 2'd0;
    rd_addr   = {5'd0, 5'd9};
    rd_tuse   = 4'd0;
    rf_data   = {RF1, RF0};
    stg_data  = {STG2, STG1, STG0};

    // reset: outputs idle, issue during reset discarded
    tick();
    tick();
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_sel0", {60'd0, fwd_sel}, 64'd0);
    check("rst_data0", {32'd0, fwd_data[31:0]}, {32'd0, RF0});
    @(negedge clk);
    reset     = 1'b1;
    iss_valid = 1'b0;
    #1;
    check("post_rst_stall", {63'd0, stall}, 64'd0);
    tick();
    #1;
    check("rst_issue_dropped_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);

    // produced result in E forwarded from stage 0
    do_flush();
    issue(5'd5, 2'd0);
    rd_addr = {5'd6, 5'd5};
    #1;
    check("e_fwd_stall", {63'd0, stall}, 64'd0);
    check("e_fwd_sel0", {62'd0, fwd_sel[1:0]}, 64'd1);
    check("e_fwd_data0", {32'd0, fwd_data[31:0]}, {32'd0, STG0});
    check("e_fwd_sel1", {62'd0, fwd_sel[3:2]}, 64'd0);
    check("e_fwd_data1", {32'd0, fwd_data[63:32]}, {32'd0, RF1});

    // load-use: one stall cycle, then bypass from M; issue during stall becomes a bubble
    do_flush();
    issue(5'd5, 2'd2);
    rd_addr   = {5'd5, 5'd5};
    rd_tuse   = {2'd1, 2'd0};
    iss_valid = 1'b1;
    iss_dst   = 5'd12;
    iss_tnew  = 2'd0;
    #1;
    check("load_stall", {63'd0, stall}, 64'd1);
    check("load_stall_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);
    check("load_stall_data0", {32'd0, fwd_data[31:0]}, {32'd0, RF0});
    check("load_late_use_sel1", {62'd0, fwd_sel[3:2]}, 64'd0);
    tick();
    iss_valid = 1'b0;
    rd_addr   = {5'd12, 5'd5};
    rd_tuse   = 4'd0;
    #1;
    check("load_m_stall", {63'd0, stall}, 64'd0);
    check("load_m_sel0", {62'd0, fwd_sel[1:0]}, 64'd2);
    check("load_m_data0", {32'd0, fwd_data[31:0]}, {32'd0, STG1});
    check("stall_issue_bubble_sel1", {62'd0, fwd_sel[3:2]}, 64'd0);

    // back-to-back writers of r7: youngest wins
    do_flush();
    issue(5'd7, 2'd0);
    issue(5'd7, 2'd0);
    rd_addr = {5'd0, 5'd7};
    #1;
    check("young_sel0", {62'd0, fwd_sel[1:0]}, 64'd1);
    check("young_data0", {32'd0, fwd_data[31:0]}, {32'd0, STG0});
    do_flush();
    issue(5'd7, 2'd0);
    issue(5'd7, 2'd2);
    rd_addr = {5'd0, 5'd7};
    #1;
    check("young_pending_stall", {63'd0, stall}, 64'd1);
    check("young_pending_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);

    // r0 never matches or stalls
    do_flush();
    issue(5'd0, 2'd2);
    rd_addr = 10'd0;
    #1;
    check("r0_stall", {63'd0, stall}, 64'd0);
    check("r0_sel", {60'd0, fwd_sel}, 64'd0);

    // flush drops pending producer and same-cycle issue
    do_flush();
    issue(5'd3, 2'd2);
    rd_addr = {5'd0, 5'd3};
    #1;
    check("pre_flush_stall", {63'd0, stall}, 64'd1);
    flush     = 1'b1;
    iss_valid = 1'b1;
    iss_dst   = 5'd3;
    iss_tnew  = 2'd0;
    tick();
    flush     = 1'b0;
    iss_valid = 1'b0;
    #1;
    check("flush_stall", {63'd0, stall}, 64'd0);
    check("flush_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);
    check("flush_data0", {32'd0, fwd_data[31:0]}, {32'd0, RF0});

    // reset mid-stall drops stall at once
    issue(5'd4, 2'd3);
    rd_addr = {5'd0, 5'd4};
    #1;
    check("pre_rst_stall", {63'd0, stall}, 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    check("rst_mid_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);
`ifdef FWD_STATS_EN
    check("rst_mid_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    @(negedge clk);
    reset   = 1'b1;
    rd_addr = 10'd0;
    tick();

    // oldest stage boundary: tnew=3 stalls two cycles, then bypass from stage 2
    issue(5'd4, 2'd3);
    rd_addr = {5'd0, 5'd4};
    #1;
    check("old_stall_a", {63'd0, stall}, 64'd1);
    tick();
    check("old_stall_b", {63'd0, stall}, 64'd1);
    tick();
    check("old_stall_c", {63'd0, stall}, 64'd0);
    check("old_sel0", {62'd0, fwd_sel[1:0]}, 64'd3);
    check("old_data0", {32'd0, fwd_data[31:0]}, {32'd0, STG2});
`ifdef FWD_STATS_EN
    check("cnt_two", {32'd0, stall_cnt}, 64'd2);
`endif
    do_flush();
    rd_addr = {5'd0, 5'd4};
    #1;
    check("aged_out_sel0", {62'd0, fwd_sel[1:0]}, 64'd0);
`ifdef FWD_STATS_EN
    check("cnt_kept_flush", {32'd0, stall_cnt}, 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
